// File: rtl/prototype_trainer_if.sv
// prototype_trainer_if: labelled feature-vector input handshake, control/status
// and prototype-memory write port of prototype_trainer.
interface prototype_trainer_if #(
    parameter int N_ELEM = 64,
    parameter int ELEM_W = 4
) ();
    logic                       start;
    logic                       s_valid;
    logic                       s_ready;
    logic [0:N_ELEM*ELEM_W-1]   s_data;
    logic                       s_label;
    logic                       wr_en;
    logic                       wr_sel;
    logic [5:0]                 wr_addr;
    logic [ELEM_W-1:0]          wr_data;
    logic                       busy;
    logic                       done;
    logic [7:0]                 dropped;

    modport master (
        output start, s_valid, s_data, s_label,
        input  s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, dropped
    );

    modport slave (
        input  start, s_valid, s_data, s_label,
        output s_ready, wr_en, wr_sel, wr_addr, wr_data, busy, done, dropped
    );
endinterface

// File: rtl/prototype_trainer.sv
// prototype_trainer: accumulates 2^LOG2_SAMPLES labelled vectors per class and
// streams both class means to the prototype memories. Define PROTO_ROUND_EN for round-half-up means.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_COLLECT | accepting vectors, summing per class until both classes full
// S_WRITE   | 128 back-to-back prototype writes (healthy, then diseased)
// S_DONE    | prototypes written; waits for the next start
module prototype_trainer #(
    parameter int N_ELEM       = 64,
    parameter int ELEM_W       = 4,
    parameter int LOG2_SAMPLES = 4
) (
    input logic                clk,
    input logic                rst,
    prototype_trainer_if.slave bus
);
    localparam int ACC_W = ELEM_W + LOG2_SAMPLES;
    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(1 << LOG2_SAMPLES);
    localparam logic [5:0]       LAST_ADDR = 6'(N_ELEM - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q [2][N_ELEM];
    logic [ACC_W-1:0]  acc_d [2][N_ELEM];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic [7:0]        dropped_q, dropped_d;
    logic              wr_en_q, wr_en_d;
    logic              wr_sel_q, wr_sel_d;
    logic [5:0]        wr_addr_q, wr_addr_d;
    logic [ELEM_W-1:0] wr_data_q, wr_data_d;
    logic              accept;

    // Accumulator never exceeds (2^ELEM_W-1)*2^LOG2_SAMPLES, so the mean fits ELEM_W bits.
    function automatic logic [ELEM_W-1:0] mean(input logic [ACC_W-1:0] a);
        logic [ACC_W:0] t;
`ifdef PROTO_ROUND_EN
        t = {1'b0, a} + (ACC_W+1)'(1 << (LOG2_SAMPLES - 1));
`else
        t = {1'b0, a};
`endif
        return ELEM_W'(t >> LOG2_SAMPLES);
    endfunction

    assign bus.s_ready = (state_q == S_COLLECT);
    assign accept      = bus.s_valid && bus.s_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dropped_d = dropped_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d   = S_COLLECT;
                    acc_d     = '{default: '0};
                    cnt_d     = '{default: '0};
                    dropped_d = '0;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (cnt_q[bus.s_label] < FULL) begin
                        for (int i = 0; i < N_ELEM; i++) begin
                            acc_d[bus.s_label][i] = acc_q[bus.s_label][i]
                                + ACC_W'(bus.s_data[i*ELEM_W +: ELEM_W]);
                        end
                        cnt_d[bus.s_label] = cnt_q[bus.s_label] + CNT_W'(1);
                    end else if (dropped_q != 8'hFF) begin
                        dropped_d = dropped_q + 8'd1;
                    end
                end
                // First write is issued on the same edge, from the freshly updated sums.
                if (cnt_d[0] == FULL && cnt_d[1] == FULL) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_sel_d  = 1'b0;
                    wr_addr_d = '0;
                    wr_data_d = mean(acc_d[0][0]);
                end
            end
            S_WRITE: begin
                if (wr_sel_q && wr_addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = wr_sel_q | (wr_addr_q == LAST_ADDR);
                    wr_addr_d = (wr_addr_q == LAST_ADDR) ? 6'd0 : wr_addr_q + 6'd1;
                    wr_data_d = mean(acc_q[wr_sel_d][wr_addr_d]);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '{default: '0};
            cnt_q     <= '{default: '0};
            dropped_q <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            dropped_q <= dropped_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = (state_q == S_COLLECT) || (state_q == S_WRITE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_prototype_trainer.sv
// tb_prototype_trainer: table-driven and randomized checks of prototype_trainer
// against a per-class sum/mean reference model.
`timescale 1ns/1ps
module tb_prototype_trainer;
    localparam int N  = 64;
    localparam int W  = 4;
    localparam int L  = 4;
    localparam int NS = 1 << L;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prototype_trainer_if #(.N_ELEM(N), .ELEM_W(W)) bus  ();
    prototype_trainer_if #(.N_ELEM(N), .ELEM_W(W)) bus1 ();

    prototype_trainer #(.N_ELEM(N), .ELEM_W(W), .LOG2_SAMPLES(L)) dut  (.clk(clk), .rst(rst), .bus(bus));
    prototype_trainer #(.N_ELEM(N), .ELEM_W(W), .LOG2_SAMPLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef logic [0:N*W-1] vec_t;
    typedef struct {
        int interleave;
        int h_val;
        int d_val;
        int h_extra;
        int h_extra_val;
        int exp_h;
        int exp_d;
        int exp_drop;
    } rec_t;

    int   checks;
    int   failures;
    vec_t q_data[$];
    bit   q_lbl[$];
    int   exp_p[2][N];
    int   got[2][N];
    int   model_drop;
    rec_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t uni(input int v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = 4'(v);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = 4'($urandom_range(0, 15));
        return r;
    endfunction

    task automatic load_table(input rec_t r);
        q_data.delete();
        q_lbl.delete();
        for (int k = 0; k < NS; k++) begin
            q_data.push_back(uni(r.h_val)); q_lbl.push_back(1'b0);
            if (r.interleave != 0) begin
                q_data.push_back(uni(r.d_val)); q_lbl.push_back(1'b1);
            end
        end
        for (int k = 0; k < r.h_extra; k++) begin
            q_data.push_back(uni(r.h_extra_val)); q_lbl.push_back(1'b0);
        end
        if (r.interleave == 0) begin
            for (int k = 0; k < NS; k++) begin
                q_data.push_back(uni(r.d_val)); q_lbl.push_back(1'b1);
            end
        end
        for (int i = 0; i < N; i++) begin
            exp_p[0][i] = r.exp_h;
            exp_p[1][i] = r.exp_d;
        end
    endtask

    // Reference model: per-class element sums of the first NS vectors, the rest dropped.
    task automatic build_random();
        int   sum[2][N];
        int   cnt[2];
        int   e[N];
        bit   lbl;
        vec_t v;
        q_data.delete();
        q_lbl.delete();
        cnt[0] = 0; cnt[1] = 0;
        model_drop = 0;
        for (int c = 0; c < 2; c++) for (int i = 0; i < N; i++) sum[c][i] = 0;
        while (cnt[0] < NS || cnt[1] < NS) begin
            lbl = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                e[i] = $urandom_range(0, 15);
                v[i*W +: W] = 4'(e[i]);
            end
            q_data.push_back(v);
            q_lbl.push_back(lbl);
            if (cnt[lbl] < NS) begin
                for (int i = 0; i < N; i++) sum[lbl][i] += e[i];
                cnt[lbl]++;
            end else if (model_drop < 255) begin
                model_drop++;
            end
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < N; i++) begin
`ifdef PROTO_ROUND_EN
                exp_p[c][i] = (sum[c][i] + NS/2) / NS;
`else
                exp_p[c][i] = sum[c][i] / NS;
`endif
            end
        end
    endtask

    task automatic send(input bit lbl, input vec_t d);
        int budget;
        budget = 0;
        bus.s_valid = 1'b1;
        bus.s_label = lbl;
        bus.s_data  = d;
        while (!bus.s_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.s_ready) chk("send_ready_timeout", 0, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    // mode 0: plain, 1: hold s_valid and pulse start during WRITE, 2: rst at sel0/addr30
    task automatic capture(input int mode, output bit aborted);
        int idx, cyc, ready_err, order_err, stray;
        bit started;
        idx = 0; cyc = 0; ready_err = 0; order_err = 0; started = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 2; c++) for (int i = 0; i < N; i++) got[c][i] = -1;
        while (cyc < 400) begin
            if (bus.wr_en) begin
                started = 1'b1;
                if (bus.s_ready) ready_err++;
                if ({bus.wr_sel, bus.wr_addr} != 7'(idx)) order_err++;
                got[bus.wr_sel][bus.wr_addr] = int'(bus.wr_data);
                if (mode == 2 && !bus.wr_sel && bus.wr_addr == 6'd30) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_mid_write_wr_en", int'(bus.wr_en), 0);
                    chk("rst_mid_write_busy", int'(bus.busy), 0);
                    chk("rst_mid_write_done", int'(bus.done), 0);
                    stray = 0;
                    repeat (6) begin
                        @(negedge clk);
                        if (bus.wr_en) stray++;
                    end
                    chk("rst_no_further_writes", stray, 0);
                    aborted = 1'b1;
                    return;
                end
                if (mode == 1) begin
                    if (idx == 10) bus.s_valid = 1'b1;
                    bus.s_data = rand_vec();
                    bus.start  = (idx == 20);
                end
                idx++;
            end else if (started) begin
                break;
            end
            @(negedge clk);
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.start   = 1'b0;
        chk("write_count", idx, 2*N);
        chk("write_order_errors", order_err, 0);
        chk("s_ready_during_write", ready_err, 0);
        chk("done_after_last_write", int'(bus.done), 1);
        chk("busy_after_last_write", int'(bus.busy), 0);
    endtask

    task automatic run_session(input int mode, input int exp_drop, input bit gaps);
        bit aborted;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_busy", int'(bus.busy), 1);
        chk("start_done", int'(bus.done), 0);
        chk("start_dropped", int'(bus.dropped), 0);
        for (int k = 0; k < q_data.size(); k++) begin
            if (gaps) begin
                bus.s_data = rand_vec();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            send(q_lbl[k], q_data[k]);
        end
        capture(mode, aborted);
        if (!aborted) begin
            chk("dropped", int'(bus.dropped), exp_drop);
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < N; i++)
                    chk($sformatf("proto_sel%0d_addr%0d", c, i), got[c][i], exp_p[c][i]);
        end
        if (mode == 1) begin
            repeat (4) @(negedge clk);
            chk("no_restart_done", int'(bus.done), 1);
            chk("no_restart_busy", int'(bus.busy), 0);
            chk("no_restart_wr_en", int'(bus.wr_en), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        tbl[0] = '{1, 3, 12, 0, 0, 3, 12, 0};
        tbl[1] = '{0, 2, 7, 4, 15, 2, 7, 4};
        tbl[2] = '{1, 15, 15, 0, 0, 15, 15, 0};
        tbl[3] = '{0, 9, 1, 300, 0, 9, 1, 255};
        tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        bus.start = 1'b0;  bus.s_valid = 1'b0;  bus.s_label = 1'b0;  bus.s_data = '0;
        bus1.start = 1'b0; bus1.s_valid = 1'b0; bus1.s_label = 1'b0; bus1.s_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", int'(bus.s_ready), 0);
        chk("reset_wr_en", int'(bus.wr_en), 0);
        chk("reset_wr_sel", int'(bus.wr_sel), 0);
        chk("reset_wr_addr", int'(bus.wr_addr), 0);
        chk("reset_wr_data", int'(bus.wr_data), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_dropped", int'(bus.dropped), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", int'(bus.s_ready), 0);

        // Two samples per class: healthy element 0 = 4 then 5.
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = '0;
            if (k == 0) v[0 +: W] = 4'd4;
            if (k == 1) v[0 +: W] = 4'd5;
            bus1.s_valid = 1'b1;
            bus1.s_label = (k >= 2);
            bus1.s_data  = v;
            chk($sformatf("l1_s_ready_%0d", k), int'(bus1.s_ready), 1);
            @(negedge clk);
        end
        bus1.s_valid = 1'b0;
        chk("l1_first_wr_en", int'(bus1.wr_en), 1);
        chk("l1_first_addr", int'({bus1.wr_sel, bus1.wr_addr}), 0);
`ifdef PROTO_ROUND_EN
        chk("l1_addr0_data", int'(bus1.wr_data), 5);
`else
        chk("l1_addr0_data", int'(bus1.wr_data), 4);
`endif
        @(negedge clk);
        chk("l1_addr1_data", int'(bus1.wr_data), 0);

        for (int r = 0; r < 5; r++) begin
            load_table(tbl[r]);
            run_session(0, tbl[r].exp_drop, 1'b0);
        end

        load_table(tbl[0]);
        run_session(1, 0, 1'b0);

        load_table(tbl[0]);
        run_session(2, 0, 1'b0);
        load_table(tbl[0]);
        run_session(0, 0, 1'b0);

        repeat (3) begin
            build_random();
            run_session(0, model_drop, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prototype_trainer.md
Name: prototype_trainer

Overview:
- Builds the healthy and diseased reference prototypes that the nearest-prototype classifier reads from its two 64×4-bit prototype memories (bram_h / bram_d).
- Accepts labelled 256-bit feature vectors, one per handshake, and accumulates per-class element sums.
- Once 2^LOG2_SAMPLES vectors per class are collected, it streams the 64-element mean of each class into the prototype-memory write port.
- Sits between the CNN feature extractor (training mode) and the prototype memories.

Parameters:
- N_ELEM, 64, elements per vector.
- ELEM_W, 4, bits per element.
- LOG2_SAMPLES, 4, log2 of samples averaged per class (16 by default); legal range 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse that clears the accumulators and begins collection.
- s_valid  in  1  input vector valid.
- s_ready  out  1  input vector accepted when s_valid&&s_ready.
- s_data  in  [0:N_ELEM*ELEM_W-1]  feature vector; element i = s_data[i*ELEM_W +: ELEM_W].
- s_label  in  1  class of the vector: 0 = healthy, 1 = diseased.
- wr_en  out  1  prototype write strobe.
- wr_sel  out  1  write target: 0 = healthy memory, 1 = diseased memory.
- wr_addr  out  6  element index.
- wr_data  out  ELEM_W  prototype element value.
- busy  out  1  high in COLLECT and WRITE.
- done  out  1  high in DONE, until the next start or rst.
- dropped  out  8  count of vectors discarded because their class was already full; saturates at 255.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state→IDLE; all accumulators and both class counters cleared.
  - Outputs: s_ready=0, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, busy=0, done=0, dropped=0.
  - Reset at any point, including mid-WRITE, aborts the operation; no further writes are issued.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE / DONE:
  - s_ready=0.
  - start→COLLECT on the next cycle; on that same edge accumulators, class counters and dropped are cleared and done drops.
- COLLECT:
  - s_ready=1 combinationally in this state.
  - On each accepted vector with label L:
    - If count[L] < 2^LOG2_SAMPLES: acc[L][i] += element i for all 64 elements in one cycle, and count[L]++.
    - Otherwise the vector is accepted and discarded, and dropped increments (saturating).
  - Accumulator width is ELEM_W+LOG2_SAMPLES; this never overflows.
  - When both counts reach 2^LOG2_SAMPLES, go to WRITE on the next edge. This holds when the final accept is for either class.
  - start in this state is ignored.
- WRITE:
  - s_ready=0; input is ignored.
  - 128 consecutive cycles with wr_en=1, one write per cycle, no stalls:
    - wr_sel=0, wr_addr 0..63;
    - then wr_sel=1, wr_addr 0..63.
  - Outputs are registered; a write is presented for exactly one cycle per address.
  - After the last write (sel=1, addr=63) go to DONE; wr_en=0 from the following cycle.
  - start is ignored.
- Mean arithmetic: wr_data = acc >> LOG2_SAMPLES (truncation), unless the optional feature is compiled in. The result is always ≤ 2^ELEM_W−1, so no saturation is needed.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: PROTO_ROUND_EN.
- Defined: wr_data = (acc + 2^(LOG2_SAMPLES−1)) >> LOG2_SAMPLES, i.e. round half up. The maximum result is still 2^ELEM_W−1.
- Undefined: plain truncation as above.

Test Plan:
1. Defaults. rst, start, then 16 healthy vectors with all elements 3 and 16 diseased vectors with all elements 12, interleaved H/D.
   - Expect 64 writes sel=0 data=3, then 64 writes sel=1 data=12, back-to-back with no gaps.
   - done=1 on the cycle after the last write; dropped=0.
2. LOG2_SAMPLES=1. Healthy element 0 values 4 and 5 (sum 9).
   - PROTO_ROUND_EN defined: addr 0 data=5.
   - PROTO_ROUND_EN undefined: addr 0 data=4.
3. Defaults. 20 healthy vectors of value 2, with the last 4 carrying value 15, then 16 diseased vectors.
   - Expect dropped=4 and healthy prototype data=2 at every address.
4. During WRITE, hold s_valid=1 and pulse start.
   - Expect s_ready=0 throughout, all 128 writes unaffected, no restart.
5. Assert rst at the write for sel=0, addr=30.
   - Expect wr_en=0, busy=0, done=0 on the next cycle; a new start + collection then produces a complete 128-write sequence.
6. All elements 15 in both classes, with and without PROTO_ROUND_EN.
   - Expect every wr_data=15 (no wrap to 0).
